// File: rtl/sram_responder.sv
// sram_responder: 16 x 8-bit memory slave with a registered read port,
// a sticky fault state for illegal commands and a saturating access counter.
module sram_responder #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              CE,
   input  logic              OE,
   input  logic              RW,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] Din,
   output logic [DATA_W-1:0] Dout,
   output logic              Dout_en,
   output logic              Err,
   output logic [CNT_W-1:0]  Acc_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                dout_en_q, dout_en_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic cmd_read, cmd_peek, cmd_write, cmd_illegal;

   // Counter stops at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      return v + CNT_W'(1);
   endfunction

   // Command decode from the active-low strobes; CE high is always idle.
   always_comb begin
      cmd_read    = !CE &&  RW && !OE;
      cmd_peek    = !CE &&  RW &&  OE;
      cmd_write   = !CE && !RW &&  OE;
      cmd_illegal = !CE && !RW && !OE;
   end

   // Next-state, memory update, output data and counter for the coming edge.
   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      dout_d    = dout_q;
      dout_en_d = 1'b0;
      err_d     = err_q;
      cnt_d     = cnt_q;
      if (state_q != ST_FAULT) begin
         if (cmd_read) begin
            state_d   = ST_READ;
            dout_d    = mem_q[Addr];
            dout_en_d = 1'b1;
            cnt_d     = sat_inc(cnt_q);
         end else if (cmd_write) begin
            state_d     = ST_WRITE;
            mem_d[Addr] = Din;
            cnt_d       = sat_inc(cnt_q);
         end else if (cmd_illegal) begin
            // Fault is sticky; only reset brings the block back.
            state_d = ST_FAULT;
            err_d   = 1'b1;
         end else begin
            // Idle and peek both leave Dout holding its last value.
            state_d = ST_IDLE;
         end
      end
   end

   // All state, including the memory array, clears on reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         dout_q    <= '0;
         dout_en_q <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         dout_q    <= dout_d;
         dout_en_q <= dout_en_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Dout    = dout_q;
   assign Dout_en = dout_en_q;
   assign Err     = err_q;
   assign Acc_cnt = cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: directed scenarios plus randomized traffic,
// all checked against a behavioural memory model held in the bench.
module tb_sram_responder;

   logic       Clk;
   logic       Rst;
   logic       CE;
   logic       OE;
   logic       RW;
   logic [3:0] Addr;
   logic [7:0] Din;
   logic [7:0] Dout;
   logic       Dout_en;
   logic       Err;
   logic [7:0] Acc_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] m_mem [16];
   logic [7:0] m_dout;
   logic       m_den;
   logic       m_err;
   int         m_cnt;
   bit         m_fault;

   sram_responder dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .CE      (CE),
      .OE      (OE),
      .RW      (RW),
      .Addr    (Addr),
      .Din     (Din),
      .Dout    (Dout),
      .Dout_en (Dout_en),
      .Err     (Err),
      .Acc_cnt (Acc_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock cycle: drive at negedge, advance model at posedge, settle #1.
   task automatic step(input bit rst, input bit ce, input bit oe, input bit rw,
                       input logic [3:0] a, input logic [7:0] d);
      @(negedge Clk);
      Rst = rst; CE = ce; OE = oe; RW = rw; Addr = a; Din = d;
      @(posedge Clk);
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = 8'h00;
         m_dout = 8'h00; m_den = 1'b0; m_err = 1'b0; m_cnt = 0; m_fault = 1'b0;
      end else if (m_fault) begin
         m_den = 1'b0;
      end else if (ce) begin
         m_den = 1'b0;
      end else if (rw) begin
         if (!oe) begin
            m_dout = m_mem[a];
            m_den  = 1'b1;
            m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
         end else begin
            m_den = 1'b0;
         end
      end else if (oe) begin
         m_mem[a] = d;
         m_den    = 1'b0;
         m_cnt    = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end else begin
         m_fault = 1'b1;
         m_err   = 1'b1;
         m_den   = 1'b0;
      end
      #1;
   endtask

   task automatic do_rst();       step(1, 1, 1, 1, 4'h0, 8'h00); endtask
   task automatic do_idle();      step(0, 1, 1, 1, 4'h0, 8'h00); endtask
   task automatic do_read(input logic [3:0] a);  step(0, 0, 0, 1, a, 8'h00); endtask
   task automatic do_peek(input logic [3:0] a);  step(0, 0, 1, 1, a, 8'h00); endtask
   task automatic do_write(input logic [3:0] a, input logic [7:0] d); step(0, 0, 1, 0, a, d); endtask

   task automatic test_reset();
      do_write(4'h1, 8'h3C);
      do_rst();
      n_checks++; if (Dout !== 8'h00)    begin n_errors++; $display("FAIL reset_dout: got %h expected 00", Dout); end
      n_checks++; if (Dout_en !== 1'b0)  begin n_errors++; $display("FAIL reset_dout_en: got %b expected 0", Dout_en); end
      n_checks++; if (Err !== 1'b0)      begin n_errors++; $display("FAIL reset_err: got %b expected 0", Err); end
      n_checks++; if (Acc_cnt !== 8'h00) begin n_errors++; $display("FAIL reset_acc_cnt: got %0d expected 0", Acc_cnt); end
      do_read(4'h1);
      n_checks++; if (Dout !== 8'h00)    begin n_errors++; $display("FAIL reset_mem_cleared: got %h expected 00", Dout); end
   endtask

   task automatic test_write_read();
      do_rst();
      do_write(4'h2, 8'hA5);
      n_checks++; if (Dout_en !== 1'b0)  begin n_errors++; $display("FAIL wr_dout_en: got %b expected 0", Dout_en); end
      do_read(4'h2);
      n_checks++; if (Dout !== 8'hA5)    begin n_errors++; $display("FAIL wr_rd_dout: got %h expected a5", Dout); end
      n_checks++; if (Dout_en !== 1'b1)  begin n_errors++; $display("FAIL wr_rd_dout_en: got %b expected 1", Dout_en); end
      n_checks++; if (Acc_cnt !== 8'd2)  begin n_errors++; $display("FAIL wr_rd_acc_cnt: got %0d expected 2", Acc_cnt); end
      // Last of consecutive writes wins.
      do_write(4'h6, 8'h10);
      do_write(4'h6, 8'h20);
      do_write(4'h6, 8'h30);
      do_read(4'h6);
      n_checks++; if (Dout !== 8'h30)    begin n_errors++; $display("FAIL last_write_wins: got %h expected 30", Dout); end
   endtask

   task automatic test_read_burst();
      logic [7:0] exp_tab [4];
      exp_tab[0] = 8'h11; exp_tab[1] = 8'h22; exp_tab[2] = 8'h33; exp_tab[3] = 8'h44;
      do_rst();
      for (int i = 0; i < 4; i++) do_write(4'(8 + i), exp_tab[i]);
      for (int i = 0; i < 4; i++) begin
         do_read(4'(8 + i));
         n_checks++; if (Dout !== exp_tab[i]) begin n_errors++; $display("FAIL burst_dout[%0d]: got %h expected %h", i, Dout, exp_tab[i]); end
         n_checks++; if (Dout_en !== 1'b1)    begin n_errors++; $display("FAIL burst_dout_en[%0d]: got %b expected 1", i, Dout_en); end
      end
      do_idle();
      n_checks++; if (Dout_en !== 1'b0)  begin n_errors++; $display("FAIL burst_idle_en: got %b expected 0", Dout_en); end
      n_checks++; if (Dout !== 8'h44)    begin n_errors++; $display("FAIL burst_idle_hold: got %h expected 44", Dout); end
      n_checks++; if (Acc_cnt !== 8'd8)  begin n_errors++; $display("FAIL burst_acc_cnt: got %0d expected 8", Acc_cnt); end
   endtask

   task automatic test_peek_idle();
      do_rst();
      do_write(4'h0, 8'hC3);
      do_write(4'h5, 8'h5A);
      do_read(4'h5);
      do_peek(4'h0);
      n_checks++; if (Dout_en !== 1'b0)  begin n_errors++; $display("FAIL peek_dout_en: got %b expected 0", Dout_en); end
      n_checks++; if (Dout !== 8'h5A)    begin n_errors++; $display("FAIL peek_dout_hold: got %h expected 5a", Dout); end
      n_checks++; if (Acc_cnt !== 8'd3)  begin n_errors++; $display("FAIL peek_acc_cnt: got %0d expected 3", Acc_cnt); end
      step(0, 1, 0, 0, 4'h0, 8'hEE); // CE high with other strobes low is idle
      n_checks++; if (Err !== 1'b0)      begin n_errors++; $display("FAIL idle_no_err: got %b expected 0", Err); end
      n_checks++; if (Dout !== 8'h5A)    begin n_errors++; $display("FAIL idle_dout_hold: got %h expected 5a", Dout); end
      do_read(4'h0);
      n_checks++; if (Dout !== 8'hC3)    begin n_errors++; $display("FAIL idle_no_write: got %h expected c3", Dout); end
   endtask

   task automatic test_illegal();
      do_rst();
      do_read(4'h3);
      step(0, 0, 0, 0, 4'h3, 8'hFF);
      n_checks++; if (Err !== 1'b1)      begin n_errors++; $display("FAIL illegal_err: got %b expected 1", Err); end
      n_checks++; if (Dout_en !== 1'b0)  begin n_errors++; $display("FAIL illegal_dout_en: got %b expected 0", Dout_en); end
      do_write(4'h3, 8'h99);
      do_read(4'h3);
      n_checks++; if (Dout_en !== 1'b0)  begin n_errors++; $display("FAIL fault_read_en: got %b expected 0", Dout_en); end
      n_checks++; if (Acc_cnt !== 8'd1)  begin n_errors++; $display("FAIL fault_acc_cnt: got %0d expected 1", Acc_cnt); end
      n_checks++; if (Err !== 1'b1)      begin n_errors++; $display("FAIL fault_sticky: got %b expected 1", Err); end
      do_rst();
      n_checks++; if (Err !== 1'b0)      begin n_errors++; $display("FAIL fault_rst_err: got %b expected 0", Err); end
      do_read(4'h3);
      n_checks++; if (Dout !== 8'h00)    begin n_errors++; $display("FAIL fault_rst_mem3: got %h expected 00", Dout); end
      n_checks++; if (Dout_en !== 1'b1)  begin n_errors++; $display("FAIL fault_rst_read_en: got %b expected 1", Dout_en); end
   endtask

   task automatic test_saturation();
      do_rst();
      for (int i = 0; i < 300; i++) do_write(4'($urandom_range(0, 15)), 8'($urandom));
      n_checks++; if (Acc_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_acc_cnt: got %0d expected 255", Acc_cnt); end
      do_read(4'h1);
      n_checks++; if (Acc_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_no_wrap: got %0d expected 255", Acc_cnt); end
      do_write(4'hF, 8'h55);
      step(1, 0, 1, 0, 4'hF, 8'h77);
      n_checks++; if (Acc_cnt !== 8'd0)   begin n_errors++; $display("FAIL sat_rst_acc_cnt: got %0d expected 0", Acc_cnt); end
      do_read(4'hF);
      n_checks++; if (Dout !== 8'h00)     begin n_errors++; $display("FAIL rst_beats_write: got %h expected 00", Dout); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] a;
      do_rst();
      for (int i = 0; i < 16; i++) do_write(4'(i), 8'($urandom));
      for (int i = 0; i < 20; i++) begin
         a = 4'($urandom_range(0, 15));
         if (i == 10) begin
            step(1, 0, 0, 1, a, 8'h00); // reset mid-burst
            n_checks++; if (Dout_en !== 1'b0) begin n_errors++; $display("FAIL b2b_rst_en: got %b expected 0", Dout_en); end
            do_write(a, 8'($urandom));
         end
         do_read(a);
         n_checks++; if (Dout !== m_mem[a]) begin n_errors++; $display("FAIL b2b_dout[%0d]: got %h expected %h", i, Dout, m_mem[a]); end
         n_checks++; if (Dout_en !== 1'b1)  begin n_errors++; $display("FAIL b2b_dout_en[%0d]: got %b expected 1", i, Dout_en); end
      end
      n_checks++; if (Acc_cnt !== 8'(m_cnt)) begin n_errors++; $display("FAIL b2b_acc_cnt: got %0d expected %0d", Acc_cnt, m_cnt); end
   endtask

   task automatic test_random();
      bit rst, ce, oe, rw;
      int r;
      do_rst();
      for (int i = 0; i < 400; i++) begin
         r   = $urandom_range(0, 99);
         rst = ($urandom_range(0, 39) == 0);
         ce  = (r < 15);
         if (r < 15)      begin oe = 1'($urandom); rw = 1'($urandom); end
         else if (r < 50) begin oe = 0; rw = 1; end
         else if (r < 60) begin oe = 1; rw = 1; end
         else if (r < 97) begin oe = 1; rw = 0; end
         else             begin oe = 0; rw = 0; end
         step(rst, ce, oe, rw, 4'($urandom_range(0, 15)), 8'($urandom));
         n_checks++; if (Dout !== m_dout)       begin n_errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, Dout, m_dout); end
         n_checks++; if (Dout_en !== m_den)     begin n_errors++; $display("FAIL rand_dout_en[%0d]: got %b expected %b", i, Dout_en, m_den); end
         n_checks++; if (Err !== m_err)         begin n_errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, Err, m_err); end
         n_checks++; if (Acc_cnt !== 8'(m_cnt)) begin n_errors++; $display("FAIL rand_acc_cnt[%0d]: got %0d expected %0d", i, Acc_cnt, m_cnt); end
      end
   endtask

   initial begin
      Rst = 1'b1; CE = 1'b1; OE = 1'b1; RW = 1'b1; Addr = 4'h0; Din = 8'h00;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_dout = 8'h00; m_den = 1'b0; m_err = 1'b0; m_cnt = 0; m_fault = 1'b0;
      test_reset();
      test_write_read();
      test_read_burst();
      test_peek_idle();
      test_illegal();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
